// File: rtl/project_pkg.sv
// project_pkg: shared types for the multicycle datapath.
//   e_alu_op    - 3-bit ALU operation code driven by the decoder
//   e_mdp_state - fetch/execute FSM state
//   JMP_*       - jump-condition encodings of ctl_jmp
//   jmp_taken() - evaluates a jump condition against the Z/C flags
package project_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_CPY = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } e_alu_op;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_FETCH_IMM = 3'd2,
        S_EXEC      = 3'd3,
        S_MEM       = 3'd4,
        S_WB        = 3'd5
    } e_mdp_state;

    localparam logic [1:0] JMP_NONE   = 2'b00;
    localparam logic [1:0] JMP_ALWAYS = 2'b01;
    localparam logic [1:0] JMP_Z      = 2'b10;
    localparam logic [1:0] JMP_C      = 2'b11;

    function automatic logic jmp_taken(input logic [1:0] cond, input logic z, input logic c);
        case (cond)
            JMP_ALWAYS: jmp_taken = 1'b1;
            JMP_Z:      jmp_taken = z;
            JMP_C:      jmp_taken = c;
            default:    jmp_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdp_alu.sv
// mdp_alu: WIDTH-generic combinational ALU for the multicycle datapath.
//   a, b   in  WIDTH  operands (a = R[rd], b = IMM or R[rs])
//   op     in  3      e_alu_op
//   res    out WIDTH  result, modulo 2^WIDTH
//   carry  out 1      carry (ADD), borrow (SUB), bit shifted out (SHL/SHR), else 0
module mdp_alu
    import project_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  e_alu_op          op,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    logic [WIDTH:0] ext;

    always_comb begin
        ext   = '0;
        res   = '0;
        carry = 1'b0;
        case (op)
            ALU_ADD: begin
                ext   = {1'b0, a} + {1'b0, b};
                res   = ext[WIDTH-1:0];
                carry = ext[WIDTH];
            end
            ALU_SUB: begin
                // Top bit of the widened difference is the borrow (a < b).
                ext   = {1'b0, a} - {1'b0, b};
                res   = ext[WIDTH-1:0];
                carry = ext[WIDTH];
            end
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_CPY: res = b;
            ALU_SHL: begin
                res   = {a[WIDTH-2:0], 1'b0};
                carry = a[WIDTH-1];
            end
            ALU_SHR: begin
                res   = {1'b0, a[WIDTH-1:1]};
                carry = a[0];
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: fetch/execute datapath with a shared req/ack memory port.
//   clk, rst                      clock (rising edge), async active-low reset
//   mem_addr/mem_rd_req/mem_wr_req/mem_wdata/mem_rdata/mem_ack
//                                 unified memory port; requests held until ack
//   instr, instr_valid            IR to the decoder; valid only in DECODE
//   ctl_*                         decoded controls, stable DECODE through WB
//   pc, flag_z, flag_c            program counter and condition flags
// The request/address outputs are registered from the next state, so the fetch
// request is raised on the first clock edge after reset release.
module multicycle_datapath
    import project_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [WIDTH-1:0]         mem_addr,
    output logic                     mem_rd_req,
    output logic                     mem_wr_req,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata,
    input  logic                     mem_ack,
    output logic [WIDTH-1:0]         instr,
    output logic                     instr_valid,
    input  logic [$clog2(NREG)-1:0]  ctl_rd,
    input  logic [$clog2(NREG)-1:0]  ctl_rs,
    input  logic [2:0]               ctl_alu_op,
    input  logic                     ctl_alu_src,
    input  logic                     ctl_rimm,
    input  logic                     ctl_mem_rd,
    input  logic                     ctl_mem_wr,
    input  logic                     ctl_reg_wr,
    input  logic                     ctl_flag_wr,
    input  logic [1:0]               ctl_jmp,
    output logic [WIDTH-1:0]         pc,
    output logic                     flag_z,
    output logic                     flag_c
);

    e_mdp_state       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, imm_q, imm_d;
    logic [WIDTH-1:0] alur_q, alur_d, mdr_q, mdr_d, addr_q, addr_d;
    logic             z_q, z_d, c_q, c_d;
    logic             rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];

    logic [WIDTH-1:0] alu_b, alu_res;
    logic             alu_carry, ack_ok;

    assign alu_b = ctl_alu_src ? imm_q : regs_q[ctl_rs];

    mdp_alu #(.WIDTH(WIDTH)) u_alu (
        .a     (regs_q[ctl_rd]),
        .b     (alu_b),
        .op    (e_alu_op'(ctl_alu_op)),
        .res   (alu_res),
        .carry (alu_carry)
    );

    // An ack only counts while a request is actually outstanding.
    assign ack_ok = mem_ack & (rd_req_q | wr_req_q);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        imm_d    = imm_q;
        alur_d   = alur_q;
        mdr_d    = mdr_q;
        z_d      = z_q;
        c_d      = c_q;
        regs_d   = regs_q;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
        addr_d   = '0;

        case (state_q)
            S_FETCH: if (ack_ok) begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + WIDTH'(1);
                state_d = S_DECODE;
            end
            S_DECODE: state_d = ctl_rimm ? S_FETCH_IMM : S_EXEC;
            S_FETCH_IMM: if (ack_ok) begin
                imm_d   = mem_rdata;
                pc_d    = pc_q + WIDTH'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alur_d = alu_res;
                if (ctl_flag_wr) begin
                    z_d = (alu_res == '0);
                    c_d = alu_carry;
                end
                state_d = (ctl_mem_rd | ctl_mem_wr) ? S_MEM : S_WB;
            end
            S_MEM: if (ack_ok) begin
                if (ctl_mem_rd) mdr_d = mem_rdata;
                state_d = S_WB;
            end
            S_WB: begin
                if (ctl_reg_wr) regs_d[ctl_rd] = ctl_mem_rd ? mdr_q : alur_q;
                if (jmp_taken(ctl_jmp, z_q, c_q)) pc_d = imm_q;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Bus outputs follow the state being entered.
        case (state_d)
            S_FETCH, S_FETCH_IMM: begin
                rd_req_d = 1'b1;
                addr_d   = pc_d;
            end
            S_MEM: begin
                rd_req_d = ctl_mem_rd;
                wr_req_d = ctl_mem_wr & ~ctl_mem_rd;
                addr_d   = alur_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            imm_q    <= '0;
            alur_q   <= '0;
            mdr_q    <= '0;
            addr_q   <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            imm_q    <= imm_d;
            alur_q   <= alur_d;
            mdr_q    <= mdr_d;
            addr_q   <= addr_d;
            z_q      <= z_d;
            c_q      <= c_d;
            rd_req_q <= rd_req_d;
            wr_req_q <= wr_req_d;
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign mem_addr    = addr_q;
    assign mem_rd_req  = rd_req_q;
    assign mem_wr_req  = wr_req_q;
    assign mem_wdata   = regs_q[ctl_rd];
    assign instr       = ir_q;
    assign instr_valid = (state_q == S_DECODE);
    assign pc          = pc_q;
    assign flag_z      = z_q;
    assign flag_c      = c_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: behavioural memory with programmable wait
// states, a small table decoder (instr[7:4] kind, [3:2] rd, [1:0] rs), and
// scoreboards of expected per-instruction state and expected memory writes.
module tb_multicycle_datapath;
    import project_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, instr, pc;
    logic       mem_rd_req, mem_wr_req, mem_ack, instr_valid, flag_z, flag_c;
    logic [1:0] ctl_rd, ctl_rs, ctl_jmp;
    logic [2:0] ctl_alu_op;
    logic       ctl_alu_src, ctl_rimm, ctl_mem_rd, ctl_mem_wr, ctl_reg_wr, ctl_flag_wr;

    always #5 clk = ~clk;

    multicycle_datapath #(.WIDTH(8), .NREG(4)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .instr(instr), .instr_valid(instr_valid),
        .ctl_rd(ctl_rd), .ctl_rs(ctl_rs), .ctl_alu_op(ctl_alu_op),
        .ctl_alu_src(ctl_alu_src), .ctl_rimm(ctl_rimm), .ctl_mem_rd(ctl_mem_rd),
        .ctl_mem_wr(ctl_mem_wr), .ctl_reg_wr(ctl_reg_wr), .ctl_flag_wr(ctl_flag_wr),
        .ctl_jmp(ctl_jmp), .pc(pc), .flag_z(flag_z), .flag_c(flag_c)
    );

    // ---------------- decoder: function of IR only ----------------
    localparam logic [3:0] K_NOP = 4'd0, K_LDI = 4'd1, K_ADDI = 4'd2, K_SUB = 4'd3,
                           K_ST  = 4'd4, K_LD  = 4'd5, K_JZ   = 4'd6, K_JMP = 4'd7;
    always_comb begin
        ctl_rd = instr[3:2]; ctl_rs = instr[1:0];
        ctl_alu_op = ALU_CPY; ctl_alu_src = 1'b0; ctl_rimm = 1'b0;
        ctl_mem_rd = 1'b0; ctl_mem_wr = 1'b0; ctl_reg_wr = 1'b0;
        ctl_flag_wr = 1'b0; ctl_jmp = JMP_NONE;
        case (instr[7:4])
            K_LDI:  begin ctl_alu_src = 1; ctl_rimm = 1; ctl_reg_wr = 1; end
            K_ADDI: begin ctl_alu_op = ALU_ADD; ctl_alu_src = 1; ctl_rimm = 1;
                          ctl_reg_wr = 1; ctl_flag_wr = 1; end
            K_SUB:  begin ctl_alu_op = ALU_SUB; ctl_reg_wr = 1; ctl_flag_wr = 1; end
            K_ST:   begin ctl_alu_src = 1; ctl_rimm = 1; ctl_mem_wr = 1; end
            K_LD:   begin ctl_alu_src = 1; ctl_rimm = 1; ctl_mem_rd = 1; ctl_reg_wr = 1; end
            K_JZ:   begin ctl_rimm = 1; ctl_jmp = JMP_Z; end
            K_JMP:  begin ctl_rimm = 1; ctl_jmp = JMP_ALWAYS; end
            default: ;
        endcase
    end

    // ---------------- memory model ----------------
    logic [7:0]  mem [256];
    int unsigned wait_cfg = 0;
    int unsigned wcnt = 0;

    assign mem_ack   = (mem_rd_req | mem_wr_req) && (wcnt == wait_cfg);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_rd_req | mem_wr_req) begin
            if (mem_ack) begin
                wcnt <= 0;
                if (mem_wr_req && !mem_rd_req) mem[mem_addr] = mem_wdata;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // ---------------- checking ----------------
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct { logic [7:0] pc; logic z; logic c; int unsigned cyc; } exp_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
    exp_t exp_q[$];
    wr_t  wr_q[$];

    task automatic push_exp(input logic [7:0] p, input logic z, input logic c, input int unsigned cyc);
        exp_t e;
        e.pc = p; e.z = z; e.c = c; e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        wr_q.push_back(w);
    endtask

    // Write scoreboard and request-hold checks on the falling edge.
    logic       prev_pend = 1'b0;
    logic [7:0] prev_addr = '0;
    logic [1:0] prev_req  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                chk("hold_addr", mem_addr, prev_addr);
                chk("hold_req", {mem_rd_req, mem_wr_req}, prev_req);
            end
            if (mem_wr_req && mem_ack) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_wdata, w.data);
                end
            end
            prev_pend = (mem_rd_req | mem_wr_req) && !mem_ack;
            prev_addr = mem_addr;
            prev_req  = {mem_rd_req, mem_wr_req};
        end
    end

    // Wait for the next DECODE cycle; returns cycles elapsed, flags a timeout.
    task automatic wait_decode(output int unsigned cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!instr_valid && cyc < 400);
        if (!instr_valid) chk("decode_timeout", 0, 1);
    endtask

    task automatic start(input int unsigned wt);
        rst = 1'b0;
        exp_q.delete();
        wr_q.delete();
        wait_cfg = wt;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        mem[a] = d;
    endtask

    // Release reset, then compare the state seen at each following DECODE.
    task automatic run(input logic [7:0] first_instr);
        int unsigned cyc;
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        wait_decode(cyc);
        chk("first_instr", instr, first_instr);
        chk("first_pc", pc, 8'h01);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_decode(cyc);
            chk("pc", pc, e.pc);
            chk("flag_z", flag_z, e.z);
            chk("flag_c", flag_c, e.c);
            chk("cycles", cyc, e.cyc);
        end
        chk("wr_drain", wr_q.size(), 0);
    endtask

    initial begin
        int unsigned cyc;

        // Reset state
        #3;
        chk("rst_rd_req", mem_rd_req, 0);
        chk("rst_wr_req", mem_wr_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_flags", {flag_z, flag_c}, 0);

        // 1) LDI R0,0x7A ; ADDI R0,0x10 ; ST R0,0x80
        start(0);
        poke(0, 8'h10); poke(1, 8'h7A); poke(2, 8'h20); poke(3, 8'h10);
        poke(4, 8'h40); poke(5, 8'h80);
        push_exp(8'h03, 0, 0, 5);
        push_exp(8'h05, 0, 0, 5);
        push_exp(8'h07, 0, 0, 6);
        push_wr(8'h80, 8'h8A);
        run(8'h10);

        // 2) carry out of ADD, then SUB R1-R1 -> zero, no borrow
        start(0);
        poke(0, 8'h14); poke(1, 8'hF0); poke(2, 8'h24); poke(3, 8'h20);
        poke(4, 8'h44); poke(5, 8'h81); poke(6, 8'h35); poke(7, 8'h44); poke(8, 8'h82);
        push_exp(8'h03, 0, 0, 5);
        push_exp(8'h05, 0, 1, 5);
        push_exp(8'h07, 0, 1, 6);
        push_exp(8'h08, 1, 0, 4);
        push_exp(8'h0A, 1, 0, 6);
        push_wr(8'h81, 8'h10);
        push_wr(8'h82, 8'h00);
        run(8'h14);

        // 3+4) three wait states: store R2 to 0x40, load back to R3, store R3
        start(3);
        poke(0, 8'h18); poke(1, 8'h55); poke(2, 8'h48); poke(3, 8'h40);
        poke(4, 8'h5C); poke(5, 8'h40); poke(6, 8'h4C); poke(7, 8'h41);
        push_exp(8'h03, 0, 0, 11);
        push_exp(8'h05, 0, 0, 15);
        push_exp(8'h07, 0, 0, 15);
        push_exp(8'h09, 0, 0, 15);
        push_wr(8'h40, 8'h55);
        push_wr(8'h41, 8'h55);
        run(8'h18);
        chk("mem_0x40", mem[8'h40], 8'h55);

        // 5) JZ taken / not taken, JMP to 0xFF, pc wraps to 0
        start(0);
        poke(8'h00, 8'h30); poke(8'h01, 8'h60); poke(8'h02, 8'h20);
        poke(8'h20, 8'h20); poke(8'h21, 8'h01);
        poke(8'h22, 8'h60); poke(8'h23, 8'h30);
        poke(8'h24, 8'h70); poke(8'h25, 8'hFF);
        poke(8'hFF, 8'h00);
        push_exp(8'h02, 1, 0, 4);
        push_exp(8'h21, 1, 0, 5);
        push_exp(8'h23, 0, 0, 5);
        push_exp(8'h25, 0, 0, 5);
        push_exp(8'h00, 0, 0, 5);
        push_exp(8'h01, 0, 0, 4);
        run(8'h30);

        // 6) async reset mid-FETCH_IMM with a read pending
        start(3);
        poke(0, 8'h30); poke(1, 8'h14); poke(2, 8'h99);
        run(8'h30);
        wait_decode(cyc);
        chk("pre_instr", instr, 8'h14);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(mem_rd_req && mem_addr == 8'h02) && cyc < 50);
        chk("pre_rst_req", mem_rd_req, 1);
        chk("pre_rst_z", flag_z, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_rd_req", mem_rd_req, 0);
        chk("arst_wr_req", mem_wr_req, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_pc", pc, 0);
        chk("arst_instr", instr, 0);
        chk("arst_flags", {flag_z, flag_c}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_decode(cyc);
        chk("post_rst_instr", instr, 8'h30);
        chk("post_rst_pc", pc, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
